univ_bin_chk: RTL and testbench

- Synthesizable checker for the universal binary counter; the observing end of the stimulus interface (syn_clr, load, en, up, d).
- Holds a cycle-accurate reference model of the counter, compares it every clock against the DUT's q, max_tick and min_tick, and records pass/fail statistics.
- Used in self-checking benches and as an on-chip monitor beside the counter.

---
 rtl/univ_bin_chk_pkg.sv | 21 ++
 rtl/univ_bin_model.sv | 51 +++++
 rtl/univ_bin_chk.sv | 131 +++++++++++++
 tb/tb_univ_bin_chk.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_bin_chk_pkg.sv
// Shared types and helpers for the universal binary counter checker.
// Holds the FSM encoding, default widths and a saturating increment.
package univ_bin_chk_pkg;

    localparam int N_DEF     = 8;
    localparam int W_CNT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] vmax
    );
        return (v >= vmax) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/univ_bin_model.sv
// Cycle-accurate reference copy of the universal binary counter.
// Ports: clk, reset, freeze, syn_clr, load, en, up, d -> model, exp_max, exp_min.
module univ_bin_model
    import univ_bin_chk_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         freeze,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] model,
    output logic         exp_max,
    output logic         exp_min
);

    logic [N-1:0] model_q, model_d;

    // Clear beats load beats count; freeze holds everything.
    always_comb begin
        model_d = model_q;
        if (freeze) begin
            model_d = model_q;
        end else if (syn_clr) begin
            model_d = '0;
        end else if (load) begin
            model_d = d;
        end else if (en && up) begin
            model_d = model_q + 1'b1;
        end else if (en) begin
            model_d = model_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            model_q <= '0;
        end else begin
            model_q <= model_d;
        end
    end

    assign model   = model_q;
    assign exp_max = &model_q;
    assign exp_min = ~|model_q;

endmodule

// File: rtl/univ_bin_chk.sv
// Checker for the universal binary counter: compares q and ticks against a model.
// Ports: stimulus (syn_clr, load, en, up, d), DUT (q, ticks) -> stats and state.
module univ_bin_chk
    import univ_bin_chk_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int W_CNT       = W_CNT_DEF,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             syn_clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    output logic             mismatch,
    output logic             err,
    output logic [W_CNT-1:0] chk_cnt,
    output logic [W_CNT-1:0] err_cnt,
    output logic [N-1:0]     first_exp,
    output logic [N-1:0]     first_got,
    output logic [1:0]       state
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << W_CNT) - 64'd1);

    state_e           state_q, state_d;
    logic             mism_q, mism_d;
    logic             err_q, err_d;
    logic [W_CNT-1:0] chk_q, chk_d;
    logic [W_CNT-1:0] errc_q, errc_d;
    logic [N-1:0]     fexp_q, fexp_d;
    logic [N-1:0]     fgot_q, fgot_d;

    logic [N-1:0]     model;
    logic             exp_max;
    logic             exp_min;
    logic             bad;

    univ_bin_model #(.N(N)) u_model (
        .clk     (clk),
        .reset   (reset),
        .freeze  (state_q == ST_HALT),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .model   (model),
        .exp_max (exp_max),
        .exp_min (exp_min)
    );

    // Compared against the pre-update model: zero-latency mirror of the DUT.
    assign bad = (q != model)
               | (max_tick != exp_max)
               | (min_tick != exp_min);

    always_comb begin
        state_d = state_q;
        mism_d  = 1'b0;
        err_d   = err_q;
        chk_d   = chk_q;
        errc_d  = errc_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;
        unique case (state_q)
            ST_IDLE: begin
                if (chk_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                chk_d = W_CNT'(sat_inc(32'(chk_q), CNT_MAX));
                if (bad) begin
                    mism_d = 1'b1;
                    err_d  = 1'b1;
                    errc_d = W_CNT'(sat_inc(32'(errc_q), CNT_MAX));
                    if (!err_q) begin
                        fexp_d = model;
                        fgot_d = q;
                    end
                end
                // A stopping error wins over disarm.
                if (bad && STOP_ON_ERR) begin
                    state_d = ST_HALT;
                end else if (!chk_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mism_q  <= 1'b0;
            err_q   <= 1'b0;
            chk_q   <= '0;
            errc_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
        end else begin
            state_q <= state_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            errc_q  <= errc_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
        end
    end

    assign mismatch  = mism_q;
    assign err       = err_q;
    assign chk_cnt   = chk_q;
    assign err_cnt   = errc_q;
    assign first_exp = fexp_q;
    assign first_got = fgot_q;
    assign state     = state_q;

endmodule

// File: tb/tb_univ_bin_chk.sv
// Bench for univ_bin_chk: three checker instances beside a behavioural counter.
// Directed table, hand sequences and a random phase against a reference model.
module tb_univ_bin_chk;

    logic       clk;
    logic       reset;
    logic       chk_en_a, chk_en_b, chk_en_c;
    logic       syn_clr, load, en, up;
    logic [7:0] d, q;
    logic       max_tick, min_tick;

    logic        a_mi, a_er, b_mi, b_er, c_mi, c_er;
    logic [15:0] a_cc, a_ec, b_cc, b_ec;
    logic [3:0]  c_cc, c_ec;
    logic [7:0]  a_fe, a_fg, b_fe, b_fg, c_fe, c_fg;
    logic [1:0]  a_st, b_st, c_st;

    univ_bin_chk #(.N(8), .W_CNT(16), .STOP_ON_ERR(1'b0)) u_a (
        .clk(clk), .reset(reset), .chk_en(chk_en_a),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .mismatch(a_mi), .err(a_er), .chk_cnt(a_cc), .err_cnt(a_ec),
        .first_exp(a_fe), .first_got(a_fg), .state(a_st)
    );

    univ_bin_chk #(.N(8), .W_CNT(16), .STOP_ON_ERR(1'b1)) u_b (
        .clk(clk), .reset(reset), .chk_en(chk_en_b),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .mismatch(b_mi), .err(b_er), .chk_cnt(b_cc), .err_cnt(b_ec),
        .first_exp(b_fe), .first_got(b_fg), .state(b_st)
    );

    univ_bin_chk #(.N(8), .W_CNT(4), .STOP_ON_ERR(1'b0)) u_c (
        .clk(clk), .reset(reset), .chk_en(chk_en_c),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .mismatch(c_mi), .err(c_er), .chk_cnt(c_cc), .err_cnt(c_ec),
        .first_exp(c_fe), .first_got(c_fg), .state(c_st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ncmp = 0;
    int nfail = 0;

    function automatic void cmp(string nm, logic [63:0] got, logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            if (nfail <= 20)
                $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    // Reference: plain integers, one slot per checker instance.
    int  cnt;
    bit  ce[3];
    int  cmax[3] = '{65535, 65535, 15};
    bit  stop[3] = '{1'b0, 1'b1, 1'b0};
    int  r_st[3], r_md[3], r_er[3], r_cc[3];
    int  r_ec[3], r_fe[3], r_fg[3], r_mi[3];

    task automatic ref_edge(input bit rst, input bit clr, input bit ld,
                            input bit e, input bit u, input int dd,
                            input int qv, input bit mt, input bit nt);
        for (int i = 0; i < 3; i++) begin
            bit bad;
            int nxt;
            if (rst) begin
                r_st[i] = 0; r_md[i] = 0; r_er[i] = 0; r_cc[i] = 0;
                r_ec[i] = 0; r_fe[i] = 0; r_fg[i] = 0; r_mi[i] = 0;
                continue;
            end
            r_mi[i] = 0;
            if (r_st[i] == 2) continue;
            bad = (qv != r_md[i]) || (mt != (r_md[i] == 255))
                  || (nt != (r_md[i] == 0));
            nxt = r_st[i];
            if (r_st[i] == 1) begin
                if (r_cc[i] < cmax[i]) r_cc[i]++;
                if (bad) begin
                    r_mi[i] = 1;
                    if (r_er[i] == 0) begin
                        r_fe[i] = r_md[i];
                        r_fg[i] = qv;
                    end
                    r_er[i] = 1;
                    if (r_ec[i] < cmax[i]) r_ec[i]++;
                end
                if (bad && stop[i]) nxt = 2;
                else if (!ce[i]) nxt = 0;
            end else if (ce[i]) begin
                nxt = 1;
            end
            r_st[i] = nxt;
            if (clr) r_md[i] = 0;
            else if (ld) r_md[i] = dd;
            else if (e) r_md[i] = u ? (r_md[i] + 1) % 256 : (r_md[i] + 255) % 256;
        end
    endtask

    task automatic check_inst(input int i, input logic mi, input logic er,
                              input logic [15:0] cc, input logic [15:0] ec,
                              input logic [7:0] fe, input logic [7:0] fg,
                              input logic [1:0] st);
        cmp($sformatf("i%0d_mismatch", i), 64'(mi), 64'(r_mi[i]));
        cmp($sformatf("i%0d_err", i), 64'(er), 64'(r_er[i]));
        cmp($sformatf("i%0d_chk_cnt", i), 64'(cc), 64'(r_cc[i]));
        cmp($sformatf("i%0d_err_cnt", i), 64'(ec), 64'(r_ec[i]));
        cmp($sformatf("i%0d_first_exp", i), 64'(fe), 64'(r_fe[i]));
        cmp($sformatf("i%0d_first_got", i), 64'(fg), 64'(r_fg[i]));
        cmp($sformatf("i%0d_state", i), 64'(st), 64'(r_st[i]));
    endtask

    // One clock: drive at negedge, edge, update references, check at negedge.
    task automatic step(input bit rst, input bit clr, input bit ld,
                        input bit e, input bit u, input logic [7:0] dd,
                        input logic [7:0] qx, input bit mx, input bit nx,
                        input bit dut_rst);
        int qv;
        bit mt, nt;
        reset    = rst;
        chk_en_a = ce[0];
        chk_en_b = ce[1];
        chk_en_c = ce[2];
        syn_clr  = clr;
        load     = ld;
        en       = e;
        up       = u;
        d        = dd;
        q        = 8'(cnt) ^ qx;
        mt       = (cnt == 255) ^ mx;
        nt       = (cnt == 0) ^ nx;
        max_tick = mt;
        min_tick = nt;
        qv       = int'(q);
        @(posedge clk);
        ref_edge(rst, clr, ld, e, u, int'(dd), qv, mt, nt);
        if (dut_rst || clr) cnt = 0;
        else if (ld) cnt = int'(dd);
        else if (e) cnt = u ? (cnt + 1) % 256 : (cnt + 255) % 256;
        @(negedge clk);
        check_inst(0, a_mi, a_er, a_cc, a_ec, a_fe, a_fg, a_st);
        check_inst(1, b_mi, b_er, b_cc, b_ec, b_fe, b_fg, b_st);
        check_inst(2, c_mi, c_er, 16'(c_cc), 16'(c_ec), c_fe, c_fg, c_st);
    endtask

    task automatic go(input bit clr, input bit ld, input bit e, input bit u,
                      input logic [7:0] dd, input logic [7:0] qx, input bit mx);
        step(1'b0, clr, ld, e, u, dd, qx, mx, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         clr, ld, e, u;
        logic [7:0] dd;
        logic [7:0] qx;
        bit         mx;
        bit         exp_mi;
        int         exp_ec;
    } vec_t;

    vec_t tbl[$];

    initial begin
        cnt = 0;
        ce  = '{1'b0, 1'b0, 1'b0};
        @(negedge clk);
        step(1'b1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1'b1);
        cmp("rst_state_a", 64'(a_st), 64'd0);
        cmp("rst_chk_a", 64'(a_cc), 64'd0);
        cmp("rst_err_b", 64'(b_er), 64'd0);

        // Arm A, then count up twelve times.
        ce[0] = 1'b1;
        go(0, 0, 0, 0, 8'h00, 8'h00, 0);
        cmp("arm_state_a", 64'(a_st), 64'd1);
        for (int i = 0; i < 12; i++) go(0, 0, 1, 1, 8'h00, 8'h00, 0);
        cmp("up12_chk_a", 64'(a_cc), 64'd12);
        cmp("up12_errc_a", 64'(a_ec), 64'd0);
        cmp("up12_err_a", 64'(a_er), 64'd0);

        for (int i = 0; i < 6; i++)
            tbl.push_back('{0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 8'h03, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 8'hAA, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 8'hFE, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 8'h00, 8'h00, 1, 1, 1});
        tbl.push_back('{0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 8'h55, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'h01, 0, 1, 2});
        tbl.push_back('{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 2});
        foreach (tbl[k]) begin
            go(tbl[k].clr, tbl[k].ld, tbl[k].e, tbl[k].u,
               tbl[k].dd, tbl[k].qx, tbl[k].mx);
            cmp($sformatf("tbl%0d_mismatch", k), 64'(a_mi), 64'(tbl[k].exp_mi));
            cmp($sformatf("tbl%0d_err_cnt", k), 64'(a_ec), 64'(tbl[k].exp_ec));
        end
        cmp("tbl_first_exp_a", 64'(a_fe), 64'hFF);
        cmp("tbl_first_got_a", 64'(a_fg), 64'hFF);

        // Stop-on-error: q = 07 against a model of 06.
        ce[1] = 1'b1;
        go(1, 0, 0, 0, 8'h00, 8'h00, 0);
        go(0, 1, 0, 0, 8'h06, 8'h00, 0);
        go(0, 0, 0, 0, 8'h00, 8'h01, 0);
        cmp("halt_err_b", 64'(b_er), 64'd1);
        cmp("halt_fexp_b", 64'(b_fe), 64'h06);
        cmp("halt_fgot_b", 64'(b_fg), 64'h07);
        cmp("halt_state_b", 64'(b_st), 64'd2);
        for (int i = 0; i < 10; i++) go(0, 0, 1, 1, 8'h00, 8'h00, 0);
        cmp("halt_chk_b", 64'(b_cc), 64'd2);
        cmp("halt_errc_b", 64'(b_ec), 64'd1);
        cmp("halt_state_b2", 64'(b_st), 64'd2);

        // Narrow counters saturate instead of wrapping.
        ce[2] = 1'b1;
        for (int i = 0; i < 21; i++) go(0, 0, 1, i[0], 8'h00, 8'h00, 0);
        cmp("sat_chk_c", 64'(c_cc), 64'hF);
        for (int i = 0; i < 20; i++) go(0, 0, 1, 1, 8'h00, 8'h80, 0);
        cmp("sat_errc_c", 64'(c_ec), 64'hF);

        // Reset out of HALT clears everything.
        step(1'b1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1'b1);
        cmp("rst_halt_state_b", 64'(b_st), 64'd0);
        cmp("rst_halt_err_b", 64'(b_er), 64'd0);
        cmp("rst_halt_chk_b", 64'(b_cc), 64'd0);
        cmp("rst_halt_fexp_b", 64'(b_fe), 64'd0);

        // Random phase against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit r, dr, mx, nx;
            logic [7:0] qx;
            for (int i = 0; i < 3; i++) ce[i] = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 63) == 0);
            dr = r || ($urandom_range(0, 127) == 0);
            qx = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            mx = ($urandom_range(0, 31) == 0);
            nx = ($urandom_range(0, 31) == 0);
            step(r, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 8'($urandom), qx, mx, nx, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
